// File: rtl/add_share_arbiter.sv
// add_share_arbiter: shares one registered adder (1-cycle latency) between
// NUM_REQ requesters. Round-robin grant, one operation in flight at a time.
// The sum comes back with the owner id on a valid/ready response channel.
// Optional build macro ADD_SHARE_ARB_CHECK_EN adds a reference sum that is
// compared with the adder result; a difference sets the sticky chk_err flag.
module add_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4,
   parameter int ID_W    = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_ip1,
   input  logic [NUM_REQ*DATA_W-1:0]   req_ip2,
   output logic [DATA_W-1:0]           add_ip1,
   output logic [DATA_W-1:0]           add_ip2,
   input  logic [DATA_W:0]             add_op,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [ID_W-1:0]             rsp_id,
   output logic [DATA_W:0]             rsp_sum,
   output logic                        busy,
   output logic                        chk_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     owner_p0;
   logic [ID_W-1:0]     grant;
   logic [ID_W-1:0]     scan_idx;
   logic                any_vld;
   logic                accept;
   logic [DATA_W-1:0]   sel_a;
   logic [DATA_W-1:0]   sel_b;

   // Full-width sum of two operands; the carry bit is kept, never truncated.
   function automatic logic [DATA_W:0] full_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant    = rr_ptr;
      any_vld  = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!any_vld && req_valid[scan_idx]) begin
            grant   = scan_idx;
            any_vld = 1'b1;
         end
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_a = req_ip1[i*DATA_W +: DATA_W];
            sel_b = req_ip2[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: one operation walks IDLE->ISSUE->WAIT->RESP->IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_vld)   state_nxt = ISSUE;
         ISSUE:                  state_nxt = WAIT;
         WAIT:                   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Output decode: ready only toward the granted requester while idle.
   always_comb begin
      accept    = (state == IDLE) && any_vld && !rst;
      busy      = (state != IDLE);
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = accept && (grant == ID_W'(i));
      end
   end

   // Stage p0: latch operands and owner on accept; they hold until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_ip1  <= '0;
         add_ip2  <= '0;
         owner_p0 <= '0;
      end else if (accept) begin
         add_ip1  <= sel_a;
         add_ip2  <= sel_b;
         owner_p0 <= grant;
      end
   end

   // Stage p1: capture the adder result in WAIT, hold it until the response is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rr_ptr    <= '0;
      end else if (state == WAIT) begin
         rsp_valid <= 1'b1;
         rsp_id    <= owner_p0;
         rsp_sum   <= add_op;
      end else if (state == RESP && rsp_ready) begin
         rsp_valid <= 1'b0;
         rr_ptr    <= (owner_p0 == ID_W'(NUM_REQ-1)) ? '0 : owner_p0 + 1'b1;
      end
   end

`ifdef ADD_SHARE_ARB_CHECK_EN
   logic [DATA_W:0] ref_sum_p0;

   // Reference sum taken from the same operands the adder will see; sticky error on disagreement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_sum_p0 <= '0;
         chk_err    <= 1'b0;
      end else begin
         if (accept) ref_sum_p0 <= full_add(sel_a, sel_b);
         if (state == WAIT && add_op != ref_sum_p0) chk_err <= 1'b1;
      end
   end
`else
   logic [DATA_W:0] unused_ref;
   assign unused_ref = full_add(add_ip1, add_ip2);
   assign chk_err    = 1'b0;
`endif

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one registered 4-bit adder (1-cycle latency, 5-bit sum) between NUM_REQ requesters.
- Each requester issues operand pairs over a valid/ready handshake.
- Round-robin arbitration selects one requester; the block drives the adder, captures the sum and returns it with the requester id over a valid/ready response channel.
- Sits between the requester ports and the adder; exactly one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand width; sum width is DATA_W+1.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand-valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_ip1  input  NUM_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ip2  input  NUM_REQ*DATA_W  packed operand B, same packing.
- add_ip1  output  DATA_W  registered operand A to the adder.
- add_ip2  output  DATA_W  registered operand B to the adder.
- add_op  input  DATA_W+1  adder sum, valid one clock after operands are applied.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester that owns rsp_sum.
- rsp_sum  output  DATA_W+1  captured sum.
- busy  output  1  high whenever state != IDLE.
- chk_err  output  1  sticky self-check error (see Optional Feature).

Behaviour:
- Reset (async assert, any state): state=IDLE; rr_ptr=0.
  - Outputs: add_ip1/add_ip2=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0, chk_err=0, req_ready=0.
  - Any in-flight operation is discarded with no response. Deassertion is used synchronously.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1, combinationally, only in IDLE and only when some req_valid=1. All other bits are 0.
  - On the clock edge where valid&ready: latch req_ip1/ip2[grant] into add_ip1/add_ip2, latch grant into owner, go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE: adder samples add_ip1/add_ip2 on this edge; go to WAIT unconditionally.
- WAIT: capture add_op into rsp_sum and owner into rsp_id; set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_sum and rsp_id stable until rsp_ready=1.
  - On the edge with rsp_valid&rsp_ready: rsp_valid=0, rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
- Latency:
  - Accept edge N -> rsp_valid high after edge N+2.
  - Minimum issue interval: 4 cycles per operation with rsp_ready held at 1.
- Handshake rules:
  - Requesters must hold valid and operands until ready.
  - Deasserting req_valid without a handshake loses no state.
  - req_ready is never high outside IDLE.
- Fairness:
  - The requester just served has lowest priority next.
  - With all requesters valid, service order is 0,1,2,3,0...
- Arithmetic: no truncation; 4'hF+4'hF returns 5'h1E. add_ip1/add_ip2 hold their value after issue until the next accept.
- add_op is ignored in every state except WAIT.

Optional Feature:
- Macro: ADD_SHARE_ARB_CHECK_EN.
- Defined:
  - The block keeps an internal reference sum (DATA_W+1 bits) of the latched operands.
  - In WAIT, if add_op differs from the reference sum, chk_err is set.
  - chk_err is sticky until rst.
  - The response is still delivered, carrying add_op unmodified.
- Not defined: no reference logic; chk_err is tied to 0.

Test Plan:
- Reset mid-operation: assert rst while in WAIT -> next cycle busy=0, rsp_valid=0, req_ready=0; after release, a new request from requester 2 is granted first (rr_ptr=0, no others valid).
- Single request: requester 1 sends ip1=4'h9, ip2=4'h8, rsp_ready=1 -> req_ready[1] in the same cycle; rsp_valid 2 cycles after accept with rsp_id=1, rsp_sum=5'h11; busy for 3 cycles.
- Overflow boundary: requester 0 sends 4'hF+4'hF -> rsp_sum=5'h1E. Requester 3 sends 0+0 -> rsp_sum=0.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches; no requester is granted twice before all others are served.
- Response backpressure: rsp_ready=0 for 5 cycles with requester 2 valid -> rsp_valid/rsp_sum/rsp_id stable, req_ready stays 0; after rsp_ready=1, the next grant occurs in the following IDLE cycle.
- With ADD_SHARE_ARB_CHECK_EN: the bench model returns a corrupted add_op (3+4 -> 5'h08) -> chk_err=1 after the WAIT edge, rsp_sum=5'h08, chk_err stays 1 until rst. Without the macro, chk_err stays 0.
